// File: rtl/branch_predictor_pkg.sv
// Shared types and encodings for the two-bit saturating-counter branch history table.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package branch_predictor_pkg;

    typedef logic [1:0] bht_cnt_t;

    localparam bht_cnt_t CNT_SNT = 2'b00;
    localparam bht_cnt_t CNT_WNT = 2'b01;
    localparam bht_cnt_t CNT_WT  = 2'b10;
    localparam bht_cnt_t CNT_ST  = 2'b11;

    localparam bht_cnt_t CNT_RST = CNT_WNT;

    // Sequential fall-through PC; wraps modulo 2^32.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state logic for a single 2-bit saturating counter.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  bht_cnt_t cur,
    input  logic     taken,
    output bht_cnt_t nxt
);

    always_comb begin
        nxt = cur;
        if (taken) begin
            if (cur != CNT_ST) nxt = cur + 2'b01;
        end else begin
            if (cur != CNT_SNT) nxt = cur - 2'b01;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Untagged 2-bit BHT: predicts at fetch, trains and flags mispredicts from the EX comparator.
// Latency: lookup and mispredict/redirect are combinational; table and counters update at the next edge.
// Backpressure: ex_stall freezes resolution; the update is taken once, on the cycle the stall drops.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_BITS = 5,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      if_pc,
    output logic             pred_taken,
    input  logic             ex_valid,
    input  logic             ex_stall,
    input  logic [31:0]      ex_pc,
    input  logic             ex_pred_taken,
    input  logic             ex_actual_taken,
    input  logic [31:0]      ex_target,
    output logic             mispredict,
    output logic [31:0]      redirect_pc,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int ENTRIES = 2 ** IDX_BITS;

    // Register array rather than SRAM so every entry clears in one reset cycle.
    bht_cnt_t bht_q [ENTRIES];

    logic [IDX_BITS-1:0] if_idx;
    logic [IDX_BITS-1:0] ex_idx;
    logic                res;
    bht_cnt_t            upd_nxt;

    assign if_idx = if_pc[IDX_BITS+1:2];
    assign ex_idx = ex_pc[IDX_BITS+1:2];
    assign res    = ex_valid & ~ex_stall;

    // Read of the registered entry: a same-cycle write to this index is seen next cycle.
    assign pred_taken = bht_q[if_idx][1];

    assign mispredict  = res & (ex_pred_taken != ex_actual_taken);
    assign redirect_pc = !mispredict     ? 32'd0 :
                         ex_actual_taken ? ex_target : pc_plus4(ex_pc);
    assign flush_if_id = mispredict;
    assign flush_id_ex = mispredict;

    sat_counter2 u_sat_counter2 (
        .cur   (bht_q[ex_idx]),
        .taken (ex_actual_taken),
        .nxt   (upd_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht_q[i] <= CNT_RST;
            end
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (res) begin
            bht_q[ex_idx] <= upd_nxt;
            branch_count  <= branch_count + CNT_W'(1);
            if (mispredict) begin
                mispredict_count <= mispredict_count + CNT_W'(1);
            end
        end
    end

    // Untagged table: PC bits outside the index never influence lookup.
    logic unused_if_pc_bits;
    assign unused_if_pc_bits = ^{if_pc[31:IDX_BITS+2], if_pc[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: reset sweep, training, saturation, wrap, collision, stall, mid-op reset.
module tb_branch_predictor;
    import branch_predictor_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic        ex_valid;
    logic        ex_stall;
    logic [31:0] ex_pc;
    logic        ex_pred_taken;
    logic        ex_actual_taken;
    logic [31:0] ex_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    int compared   = 0;
    int mismatched = 0;

    branch_predictor #(.IDX_BITS(5), .CNT_W(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .if_pc            (if_pc),
        .pred_taken       (pred_taken),
        .ex_valid         (ex_valid),
        .ex_stall         (ex_stall),
        .ex_pc            (ex_pc),
        .ex_pred_taken    (ex_pred_taken),
        .ex_actual_taken  (ex_actual_taken),
        .ex_target        (ex_target),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .flush_if_id      (flush_if_id),
        .flush_id_ex      (flush_id_ex),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic drive_ex(input logic v, input logic stall, input logic [31:0] pc,
                            input logic pred, input logic act, input logic [31:0] tgt);
        ex_valid        = v;
        ex_stall        = stall;
        ex_pc           = pc;
        ex_pred_taken   = pred;
        ex_actual_taken = act;
        ex_target       = tgt;
        #1;
    endtask

    task automatic check_resolve(input string tag, input logic mp, input logic [31:0] rpc);
        chk({tag, "_mispredict"}, 32'(mispredict), 32'(mp));
        chk({tag, "_redirect"}, redirect_pc, rpc);
        chk({tag, "_flush_if_id"}, 32'(flush_if_id), 32'(mp));
        chk({tag, "_flush_id_ex"}, 32'(flush_id_ex), 32'(mp));
    endtask

    task automatic check_counts(input string tag, input logic [31:0] bc, input logic [31:0] mc);
        chk({tag, "_branch_count"}, branch_count, bc);
        chk({tag, "_mispredict_count"}, mispredict_count, mc);
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc, input logic exp);
        if_pc = pc;
        #1;
        chk(tag, 32'(pred_taken), 32'(exp));
    endtask

    initial begin
        rst = 1'b1;
        if_pc = 32'd0;
        drive_ex(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);

        // Reset, then sweep every entry.
        tick;
        rst = 1'b0;
        #1;
        chk("reset_pred", 32'(pred_taken), 32'd0);
        check_resolve("reset", 1'b0, 32'd0);
        check_counts("reset", 32'd0, 32'd0);
        for (int i = 0; i < 32; i++) begin
            lookup($sformatf("sweep_%0d", i), 32'(i * 4), 1'b0);
        end

        // Training at 0x40 (index 16): WNT -> WT -> ST -> WT.
        drive_ex(1'b1, 1'b0, 32'h40, 1'b0, 1'b1, 32'h100);
        check_resolve("train1", 1'b1, 32'h100);
        tick;
        drive_ex(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        lookup("train1_pred", 32'h40, 1'b1);
        chk("train1_entry", 32'(dut.bht_q[16]), 32'(CNT_WT));
        drive_ex(1'b1, 1'b0, 32'h40, 1'b1, 1'b1, 32'h100);
        check_resolve("train2", 1'b0, 32'd0);
        tick;
        drive_ex(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("train2_entry", 32'(dut.bht_q[16]), 32'(CNT_ST));
        drive_ex(1'b1, 1'b0, 32'h40, 1'b1, 1'b0, 32'h100);
        check_resolve("train3", 1'b1, 32'h44);
        tick;
        drive_ex(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("train3_entry", 32'(dut.bht_q[16]), 32'(CNT_WT));
        lookup("train3_pred", 32'h40, 1'b1);
        check_counts("train", 32'd3, 32'd2);

        // Saturation at 0x80 (index 0): five not-taken resolves.
        for (int i = 0; i < 5; i++) begin
            drive_ex(1'b1, 1'b0, 32'h80, 1'b0, 1'b0, 32'h400);
            tick;
        end
        drive_ex(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("sat_entry", 32'(dut.bht_q[0]), 32'(CNT_SNT));
        lookup("sat_pred", 32'h80, 1'b0);
        check_counts("sat", 32'd8, 32'd2);

        // Fall-through redirect wraps to zero.
        drive_ex(1'b1, 1'b0, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h1234);
        check_resolve("wrap", 1'b1, 32'h0000_0000);
        tick;
        drive_ex(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("wrap_entry", 32'(dut.bht_q[31]), 32'(CNT_SNT));
        check_counts("wrap", 32'd9, 32'd3);

        // Same-index lookup and update: old value now, new value next cycle.
        if_pc = 32'h10;
        drive_ex(1'b1, 1'b0, 32'h10, 1'b0, 1'b1, 32'h80);
        chk("collide_old", 32'(pred_taken), 32'd0);
        check_resolve("collide", 1'b1, 32'h80);
        tick;
        drive_ex(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("collide_new", 32'(pred_taken), 32'd1);
        check_counts("collide", 32'd10, 32'd4);

        // Stall held for three cycles, then released.
        for (int i = 0; i < 3; i++) begin
            drive_ex(1'b1, 1'b1, 32'h20, 1'b0, 1'b1, 32'h200);
            check_resolve($sformatf("stall_%0d", i), 1'b0, 32'd0);
            tick;
            chk($sformatf("stall_%0d_count", i), branch_count, 32'd10);
        end
        drive_ex(1'b1, 1'b0, 32'h20, 1'b0, 1'b1, 32'h200);
        check_resolve("release", 1'b1, 32'h200);
        tick;
        drive_ex(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check_counts("release", 32'd11, 32'd5);
        chk("release_entry", 32'(dut.bht_q[8]), 32'(CNT_WT));

        // Bring 0x40 back to ST, then reset against a simultaneous taken resolve.
        drive_ex(1'b1, 1'b0, 32'h40, 1'b1, 1'b1, 32'h100);
        tick;
        drive_ex(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("pre_rst_entry", 32'(dut.bht_q[16]), 32'(CNT_ST));
        check_counts("pre_rst", 32'd12, 32'd5);
        rst = 1'b1;
        drive_ex(1'b1, 1'b0, 32'h40, 1'b0, 1'b1, 32'h100);
        tick;
        rst = 1'b0;
        drive_ex(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("mid_rst_entry", 32'(dut.bht_q[16]), 32'(CNT_WNT));
        chk("mid_rst_entry0", 32'(dut.bht_q[0]), 32'(CNT_WNT));
        chk("mid_rst_entry31", 32'(dut.bht_q[31]), 32'(CNT_WNT));
        check_counts("mid_rst", 32'd0, 32'd0);
        lookup("mid_rst_pred", 32'h40, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
